bp_perf_monitor: RTL
====================

Name: bp_perf_monitor

Overview:
- Synthesizable performance-counter block for the pipelined RISC-V core with branch predictor.
- Taps the core's fetch-stage prediction and execute-stage resolution.
- Aligns the fetch-time prediction to its instruction through a stall/flush-aware delay line.
- Counts cycles, instructions, branches, jumps and mispredictions, plus per-PC-bucket miss counts.
- Counters are read through a snapshot/select port, so software or a bench can sample them without disturbing counting.

Parameters:
CNT_W, 32, counter width in bits
PC_W, 32, PC width
PIPE_DEPTH, 2, stages from fetch (prediction) to execute (resolution); legal values 1..4
NUM_BUCKETS, 4, per-PC miss buckets; power of two, 1..16
BUCKET_LSB, 2, lowest PC bit used for the bucket index

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
count_en_i  in  1  global counting enable
clear_i  in  1  zero all live counters
snap_i  in  1  copy live counters into the shadow bank
adv_i  in  1  pipeline advance (low = stall); the delay line shifts only when high
flush_i  in  1  invalidate delay-line entries younger than execute
pred_taken_f_i  in  1  predictor taken bit, fetch stage
pred_pc_f_i  in  PC_W  fetch PC
instr_valid_d_i  in  1  non-bubble instruction in decode
ex_valid_i  in  1  instruction in execute is valid
ex_is_branch_i  in  1  conditional branch in execute
ex_is_jump_i  in  1  jal/jalr in execute
ex_taken_i  in  1  actual branch outcome
rd_sel_i  in  SEL_W  shadow counter select; SEL_W = clog2(6+NUM_BUCKETS)
rd_data_o  out  CNT_W  selected shadow counter
rd_valid_o  out  1  rd_data_o is valid
overflow_o  out  6+NUM_BUCKETS  sticky overflow mask

Behaviour:
- Reset (synchronous, active-high, clock clk):
  - All live and shadow counters, delay-line entries (valid and data), rd_data_o, rd_valid_o and overflow_o go to 0.
- Delay line: PIPE_DEPTH entries, each {valid, taken, pc}.
  - When adv_i=1: entry0 <= {1, pred_taken_f_i, pred_pc_f_i} and the remaining entries shift.
  - When adv_i=0: all entries hold.
  - When flush_i=1: entries 0..PIPE_DEPTH-2 have valid cleared in the same cycle; flush takes precedence over the shift.
  - The tail entry (E) is the prediction for the instruction in execute.
- Counter indices:
  - 0 cycles: +1 every cycle while count_en_i=1.
  - 1 instructions: +1 when instr_valid_d_i.
  - 2 branches: +1 when ex_valid_i & ex_is_branch_i & adv_i.
  - 3 branch misses: as for index 2, and additionally E.valid=0 or E.taken != ex_taken_i.
  - 4 jumps: +1 when ex_valid_i & ex_is_jump_i & adv_i.
  - 5 jump misses: as for index 4, and additionally E.valid=0 or E.taken=0.
  - 6+b: +1 on any branch or jump miss where b = E.pc[BUCKET_LSB +: clog2(NUM_BUCKETS)]; when E.valid=0, b=0.
- Events count only while count_en_i=1. A stalled execute (adv_i=0) is not counted, so no instruction is double-counted.
- Clear: clear_i has priority over any same-cycle increment; the counter becomes 0, not 1.
- Saturation: counters stop at 2^CNT_W-1 (default build).
- Snapshot:
  - snap_i copies the live values at the clock edge, before the same-cycle increment is applied.
  - snap_i together with clear_i captures the pre-clear values.
- Read port: one-cycle latency. rd_data_o <= shadow[rd_sel_i]; rd_valid_o <= 1 one cycle after any rd_sel_i sample following reset. An out-of-range rd_sel_i returns 0.
- Reset asserted mid-run: everything returns to reset values on that edge, including any in-flight read.

Optional Feature:
- Macro: PERF_MON_OVERFLOW_EN.
- When defined:
  - Counters wrap modulo 2^CNT_W instead of saturating.
  - A wrap sets the corresponding bit of overflow_o, which is sticky until clear_i or reset.
- When undefined: counters saturate and overflow_o is tied to 0.

Decomposition:
- Shared package bp_perf_pkg holds:
  - counter index constants: CNT_CYCLES=0, CNT_INSTR=1, CNT_BR=2, CNT_BR_MISS=3, CNT_JMP=4, CNT_JMP_MISS=5, CNT_BUCKET0=6;
  - NUM_FIXED_CNT=6;
  - the pred_entry_t {valid, taken, pc} typedef.
- One sub-module: bp_perf_counter (a single CNT_W counter with inc, clear, saturate/wrap and overflow flag), instantiated 6+NUM_BUCKETS times.

Test Plan:
1. Reset, then 100 cycles with count_en=1, adv=1, no events -> after snap and read of sel 0: cycle count 100; sel 1..9 read 0.
2. Predict taken for PC 0x10, which resolves in execute as not taken 2 cycles later -> branches=1, branch misses=1, bucket (0x10>>2)&3 = 0 gets 1; the same sequence with ex_taken=1 -> branches=2, misses unchanged.
3. adv=0 for 3 cycles while a branch sits in execute -> counted exactly once; a flush while a prediction is in flight -> E.valid=0, and the following jump counts as a jump miss.
4. clear_i together with an instruction event -> instruction count 0; snap_i together with clear_i -> shadow holds the pre-clear value.
5. CNT_W=4, 20 instruction events -> default build: 15, overflow_o=0; with PERF_MON_OVERFLOW_EN: 4, overflow_o[1]=1 until clear.
6. rd_sel=15 with NUM_BUCKETS=4 -> rd_data_o=0 and rd_valid_o=1 one cycle later; reset asserted during the read -> rd_valid_o=0.

Source files
------------

// File: rtl/bp_perf_pkg.sv
// rtl/bp_perf_pkg.sv - shared counter indices and prediction-entry type for bp_perf_monitor
package bp_perf_pkg;

   localparam int CNT_CYCLES    = 0;
   localparam int CNT_INSTR     = 1;
   localparam int CNT_BR        = 2;
   localparam int CNT_BR_MISS   = 3;
   localparam int CNT_JMP       = 4;
   localparam int CNT_JMP_MISS  = 5;
   localparam int CNT_BUCKET0   = 6;
   localparam int NUM_FIXED_CNT = 6;

   // Widest PC carried through the delay line; narrower PCs are zero-extended.
   localparam int PRED_PC_W = 32;

   typedef struct packed {
      logic                 valid;
      logic                 taken;
      logic [PRED_PC_W-1:0] pc;
   } pred_entry_t;

endpackage

// File: rtl/bp_perf_counter.sv
// rtl/bp_perf_counter.sv - one event counter; saturates, or wraps with sticky overflow under PERF_MON_OVERFLOW_EN
module bp_perf_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clear,
   output logic [CNT_W-1:0] value,
   output logic             overflow
);

`ifdef PERF_MON_OVERFLOW_EN
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         value    <= '0;
         overflow <= 1'b0;
      end else if (inc) begin
         value <= value + CNT_W'(1);
         if (&value) overflow <= 1'b1;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         value <= '0;
      end else if (inc && !(&value)) begin
         value <= value + CNT_W'(1);
      end
   end

   assign overflow = 1'b0;
`endif

endmodule

// File: rtl/bp_perf_monitor.sv
// rtl/bp_perf_monitor.sv - branch-predictor performance monitor with snapshot read port (option: PERF_MON_OVERFLOW_EN)
module bp_perf_monitor
   import bp_perf_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int PC_W        = 32,
   parameter int PIPE_DEPTH  = 2,
   parameter int NUM_BUCKETS = 4,
   parameter int BUCKET_LSB  = 2,
   parameter int SEL_W       = $clog2(NUM_FIXED_CNT + NUM_BUCKETS)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             count_en_i,
   input  logic                             clear_i,
   input  logic                             snap_i,
   input  logic                             adv_i,
   input  logic                             flush_i,
   input  logic                             pred_taken_f_i,
   input  logic [PC_W-1:0]                  pred_pc_f_i,
   input  logic                             instr_valid_d_i,
   input  logic                             ex_valid_i,
   input  logic                             ex_is_branch_i,
   input  logic                             ex_is_jump_i,
   input  logic                             ex_taken_i,
   input  logic [SEL_W-1:0]                 rd_sel_i,
   output logic [CNT_W-1:0]                 rd_data_o,
   output logic                             rd_valid_o,
   output logic [NUM_FIXED_CNT+NUM_BUCKETS-1:0] overflow_o
);

   localparam int NUM_CNT = NUM_FIXED_CNT + NUM_BUCKETS;
   localparam int BK_W    = (NUM_BUCKETS > 1) ? $clog2(NUM_BUCKETS) : 1;

   pred_entry_t        pipe [PIPE_DEPTH];
   pred_entry_t        ex_pred;
   logic [NUM_CNT-1:0] inc;
   logic [CNT_W-1:0]   live   [NUM_CNT];
   logic [CNT_W-1:0]   shadow [NUM_CNT];
   logic               br_ev, jmp_ev, br_miss, jmp_miss;
   logic [BK_W-1:0]    bucket;
   logic               unused_pc;

   // Flush only kills entries younger than execute; it overrides the shift-in.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < PIPE_DEPTH; i++) pipe[i] <= '0;
      end else begin
         if (adv_i) begin
            pipe[0] <= '{valid: 1'b1, taken: pred_taken_f_i, pc: PRED_PC_W'(pred_pc_f_i)};
            for (int i = 1; i < PIPE_DEPTH; i++) pipe[i] <= pipe[i-1];
         end
         if (flush_i) begin
            for (int i = 0; i < PIPE_DEPTH - 1; i++) pipe[i].valid <= 1'b0;
         end
      end
   end

   assign ex_pred   = pipe[PIPE_DEPTH-1];
   assign unused_pc = ^ex_pred.pc;

   assign br_ev    = count_en_i & ex_valid_i & ex_is_branch_i & adv_i;
   assign jmp_ev   = count_en_i & ex_valid_i & ex_is_jump_i & adv_i;
   assign br_miss  = br_ev & (!ex_pred.valid | (ex_pred.taken != ex_taken_i));
   assign jmp_miss = jmp_ev & (!ex_pred.valid | !ex_pred.taken);
   assign bucket   = (ex_pred.valid && NUM_BUCKETS > 1) ? ex_pred.pc[BUCKET_LSB +: BK_W] : '0;

   always_comb begin
      inc               = '0;
      inc[CNT_CYCLES]   = count_en_i;
      inc[CNT_INSTR]    = count_en_i & instr_valid_d_i;
      inc[CNT_BR]       = br_ev;
      inc[CNT_BR_MISS]  = br_miss;
      inc[CNT_JMP]      = jmp_ev;
      inc[CNT_JMP_MISS] = jmp_miss;
      for (int b = 0; b < NUM_BUCKETS; b++) begin
         inc[CNT_BUCKET0+b] = (br_miss | jmp_miss) && (bucket == BK_W'(b));
      end
   end

   for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
      bp_perf_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk      (clk),
         .reset    (reset),
         .inc      (inc[i]),
         .clear    (clear_i),
         .value    (live[i]),
         .overflow (overflow_o[i])
      );
   end

   // Shadow takes the pre-edge live values, so snap+clear keeps the old counts.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_CNT; i++) shadow[i] <= '0;
         rd_data_o  <= '0;
         rd_valid_o <= 1'b0;
      end else begin
         if (snap_i) begin
            for (int i = 0; i < NUM_CNT; i++) shadow[i] <= live[i];
         end
         rd_valid_o <= 1'b1;
         rd_data_o  <= (int'(rd_sel_i) < NUM_CNT) ? shadow[rd_sel_i] : '0;
      end
   end

endmodule
